// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port among NumPorts requesters, one transaction at a time.
// Latency: mem_req_o one cycle after req_i; gnt_o one cycle after mem_gnt_i. Requesters wait, holding req_i, until their gnt_o pulse.
module mem_arbiter #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int NumPorts  = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumPorts-1:0]             req_i,
  input  logic [NumPorts-1:0]             rw_i,
  input  logic [NumPorts*AddrWidth-1:0]   addr_i,
  input  logic [NumPorts*DataWidth-1:0]   wdata_i,
  output logic [NumPorts-1:0]             gnt_o,
  output logic [DataWidth-1:0]            rdata_o,
  output logic                            busy_o,
  output logic [$clog2(NumPorts)-1:0]     owner_o,
  output logic                            mem_req_o,
  input  logic                            mem_gnt_i,
  output logic                            mem_rw_o,
  output logic [AddrWidth-1:0]            mem_addr_o,
  output logic [DataWidth-1:0]            mem_wdata_o,
  input  logic [DataWidth-1:0]            mem_rdata_i
);

  localparam int OW = $clog2(NumPorts);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state;
  logic [OW-1:0]       ptr;
  logic [NumPorts-1:0] mask;
  logic [NumPorts-1:0] elig;
  logic                win_vld;
  logic [OW-1:0]       win;

  // First eligible port at or above ptr, wrapping; mask hides the port just served.
  always_comb begin
    elig    = req_i & ~mask;
    win_vld = 1'b0;
    win     = ptr;
    for (int i = 0; i < NumPorts; i++) begin
      if (!win_vld && elig[(int'(ptr) + i) % NumPorts]) begin
        win_vld = 1'b1;
        win     = OW'((int'(ptr) + i) % NumPorts);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      ptr         <= '0;
      mask        <= '0;
      gnt_o       <= '0;
      rdata_o     <= '0;
      busy_o      <= 1'b0;
      owner_o     <= '0;
      mem_req_o   <= 1'b0;
      mem_rw_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          mask  <= '0;
          gnt_o <= '0;
          if (win_vld) begin
            owner_o     <= win;
            mem_rw_o    <= rw_i[win];
            mem_addr_o  <= addr_i[int'(win)*AddrWidth +: AddrWidth];
            mem_wdata_o <= wdata_i[int'(win)*DataWidth +: DataWidth];
            mem_req_o   <= 1'b1;
            busy_o      <= 1'b1;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (mem_gnt_i) begin
            rdata_o   <= mem_rdata_i;
            mem_req_o <= 1'b0;
            gnt_o     <= NumPorts'(1) << owner_o;
            state     <= DONE;
          end
        end
        DONE: begin
          gnt_o  <= '0;
          busy_o <= 1'b0;
          mask   <= NumPorts'(1) << owner_o;
          ptr    <= (owner_o == OW'(NumPorts - 1)) ? '0 : owner_o + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single-port transactions plus hand sequences
// for contention, fairness, mid-transaction input changes, reset abort and stray memory pulses.
module tb_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  req_i, rw_i;
  logic [63:0] addr_i, wdata_i;
  logic [1:0]  gnt_o;
  logic [31:0] rdata_o;
  logic        busy_o;
  logic        owner_o;
  logic        mem_req_o, mem_gnt_i, mem_rw_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(.AddrWidth(32), .DataWidth(32), .NumPorts(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .rw_i(rw_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .rdata_o(rdata_o), .busy_o(busy_o),
    .owner_o(owner_o), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
    .mem_rw_o(mem_rw_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  // Memory model: answers after 'latency' cycles of mem_req_o, driven 2 ns after each edge.
  logic [31:0] mem [logic [31:0]];
  int          latency = 2;
  bit          stray = 1'b0;
  int          cnt = 0;

  initial begin
    mem_gnt_i   = 1'b0;
    mem_rdata_i = 32'h0;
    forever begin
      @(posedge clk_i);
      #2;
      mem_gnt_i = 1'b0;
      if (rst_i) begin
        cnt = 0;
      end else if (mem_req_o) begin
        cnt++;
        if (cnt >= latency) begin
          cnt = 0;
          mem_gnt_i = 1'b1;
          if (mem_rw_o) mem[mem_addr_o] = mem_wdata_o;
          else mem_rdata_i = mem.exists(mem_addr_o) ? mem[mem_addr_o] : 32'h0;
        end
      end else begin
        cnt = 0;
        if (stray) begin
          mem_gnt_i   = 1'b1;
          mem_rdata_i = 32'hFFFF_FFFF;
        end
      end
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  task automatic wait_gnt(output logic [1:0] g);
    g = 2'b00;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      if (gnt_o != 2'b00) begin
        g = gnt_o;
        return;
      end
    end
  endtask

  task automatic reset_dut();
    @(negedge clk_i);
    rst_i = 1'b1;
    req_i = 2'b00;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  typedef struct {
    int          port;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vecs [6];
  logic [1:0]  g;
  logic [1:0]  order [16];
  int          ng, lowcnt, pulses;
  logic [31:0] cap;

  initial begin
    rst_i = 1'b1; req_i = 2'b00; rw_i = 2'b00; addr_i = 64'h0; wdata_i = 64'h0;
    mem[32'h40]  = 32'hA5A5_0001;
    mem[32'h300] = 32'h0BAD_0300;
    mem[32'h100] = 32'h0;
    mem[32'h200] = 32'h0;

    vecs[0] = '{0, 1'b0, 32'h40, 32'h0,         32'hA5A5_0001};
    vecs[1] = '{1, 1'b1, 32'h80, 32'hDEAD_BEEF, 32'h0};
    vecs[2] = '{1, 1'b0, 32'h80, 32'h0,         32'hDEAD_BEEF};
    vecs[3] = '{0, 1'b1, 32'h44, 32'h1234_5678, 32'h0};
    vecs[4] = '{0, 1'b0, 32'h44, 32'h0,         32'h1234_5678};
    vecs[5] = '{1, 1'b0, 32'h40, 32'h0,         32'hA5A5_0001};

    repeat (3) @(negedge clk_i);
    check("rst_gnt",       64'(gnt_o),       64'd0);
    check("rst_rdata",     64'(rdata_o),     64'd0);
    check("rst_busy",      64'(busy_o),      64'd0);
    check("rst_owner",     64'(owner_o),     64'd0);
    check("rst_mem_req",   64'(mem_req_o),   64'd0);
    check("rst_mem_rw",    64'(mem_rw_o),    64'd0);
    check("rst_mem_addr",  64'(mem_addr_o),  64'd0);
    check("rst_mem_wdata", 64'(mem_wdata_o), 64'd0);
    rst_i = 1'b0;

    for (int v = 0; v < 6; v++) begin
      int p;
      p = vecs[v].port;
      @(negedge clk_i);
      req_i[p] = 1'b1;
      rw_i[p] = vecs[v].rw;
      addr_i[p*32 +: 32] = vecs[v].addr;
      wdata_i[p*32 +: 32] = vecs[v].wdata;
      check("tbl_req_before", 64'(mem_req_o), 64'd0);
      @(negedge clk_i);
      check("tbl_req_after",  64'(mem_req_o),  64'd1);
      check("tbl_mem_addr",   64'(mem_addr_o), 64'(vecs[v].addr));
      check("tbl_mem_rw",     64'(mem_rw_o),   64'(vecs[v].rw));
      check("tbl_busy",       64'(busy_o),     64'd1);
      check("tbl_owner",      64'(owner_o),    64'(p));
      if (vecs[v].rw) check("tbl_mem_wdata", 64'(mem_wdata_o), 64'(vecs[v].wdata));
      wait_gnt(g);
      req_i[p] = 1'b0;
      check("tbl_gnt", 64'(g), 64'(2'b01 << p));
      if (!vecs[v].rw) check("tbl_rdata", 64'(rdata_o), 64'(vecs[v].exp_rdata));
      @(negedge clk_i);
      check("tbl_busy_after", 64'(busy_o), 64'd0);
      check("tbl_gnt_after",  64'(gnt_o),  64'd0);
    end

    // Simultaneous writes: port0 first, then port1, with a 2-cycle gap in mem_req_o.
    reset_dut();
    latency = 2;
    @(negedge clk_i);
    req_i = 2'b11; rw_i = 2'b11;
    addr_i  = {32'h200, 32'h100};
    wdata_i = {32'h2222_2222, 32'h1111_1111};
    ng = 0; lowcnt = 0;
    for (int i = 0; i < 100 && ng < 2; i++) begin
      @(negedge clk_i);
      if (gnt_o != 2'b00) begin
        order[ng] = gnt_o;
        ng++;
        req_i = req_i & ~gnt_o;
      end
      if (ng == 1 && !mem_req_o) lowcnt++;
    end
    check("sim_count",  64'(ng),     64'd2);
    check("sim_first",  64'(order[0]), 64'(2'b01));
    check("sim_second", 64'(order[1]), 64'(2'b10));
    check("sim_mem100", 64'(mem[32'h100]), 64'h1111_1111);
    check("sim_mem200", 64'(mem[32'h200]), 64'h2222_2222);
    check("sim_gap",    64'(lowcnt), 64'd2);

    // Continuous requests from both ports must alternate strictly.
    reset_dut();
    latency = 1;
    @(negedge clk_i);
    req_i = 2'b11; rw_i = 2'b00; addr_i = {32'h40, 32'h40};
    ng = 0;
    for (int i = 0; i < 400 && ng < 16; i++) begin
      @(negedge clk_i);
      if (gnt_o != 2'b00) begin
        order[ng] = gnt_o;
        ng++;
      end
    end
    req_i = 2'b00;
    check("fair_count", 64'(ng), 64'd16);
    for (int k = 0; k < 16; k++)
      check($sformatf("fair_grant%0d", k), 64'(order[k]), (k % 2 == 0) ? 64'd1 : 64'd2);
    repeat (3) @(negedge clk_i);

    // Port1 changes address and drops req_i while its access is in flight.
    reset_dut();
    latency = 5;
    @(negedge clk_i);
    req_i[1] = 1'b1; rw_i[1] = 1'b0; addr_i[63:32] = 32'h300;
    @(negedge clk_i);
    check("mid_addr_start", 64'(mem_addr_o), 64'h300);
    addr_i[63:32] = 32'h304;
    req_i[1] = 1'b0;
    pulses = 0; cap = 32'h0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (i == 1) begin
        check("mid_addr_hold", 64'(mem_addr_o), 64'h300);
        check("mid_req_hold",  64'(mem_req_o),  64'd1);
      end
      if (gnt_o[1]) begin
        pulses++;
        cap = rdata_o;
      end
    end
    check("mid_pulses", 64'(pulses), 64'd1);
    check("mid_rdata",  64'(cap),    64'h0BAD_0300);

    // Reset during a long access aborts it with no grant.
    latency = 100;
    @(negedge clk_i);
    req_i[0] = 1'b1; rw_i[0] = 1'b0; addr_i[31:0] = 32'h40;
    @(negedge clk_i);
    check("rst_mid_req_up", 64'(mem_req_o), 64'd1);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    req_i = 2'b00;
    @(negedge clk_i);
    check("rst_mid_req",  64'(mem_req_o), 64'd0);
    check("rst_mid_busy", 64'(busy_o),    64'd0);
    check("rst_mid_gnt",  64'(gnt_o),     64'd0);
    rst_i = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (gnt_o != 2'b00) pulses++;
    end
    check("rst_mid_nognt", 64'(pulses), 64'd0);
    latency = 2;
    @(negedge clk_i);
    req_i[0] = 1'b1;
    wait_gnt(g);
    req_i[0] = 1'b0;
    check("post_rst_gnt",   64'(g),       64'd1);
    check("post_rst_rdata", 64'(rdata_o), 64'hA5A5_0001);
    repeat (2) @(negedge clk_i);

    // A memory completion pulse while idle is ignored.
    stray = 1'b1;
    @(negedge clk_i);
    stray = 1'b0;
    @(negedge clk_i);
    check("stray_gnt",   64'(gnt_o),     64'd0);
    check("stray_busy",  64'(busy_o),    64'd0);
    check("stray_req",   64'(mem_req_o), 64'd0);
    check("stray_owner", 64'(owner_o),   64'd0);
    check("stray_rdata", 64'(rdata_o),   64'hA5A5_0001);
    repeat (2) @(negedge clk_i);
    check("stray_settle", 64'(busy_o), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

endmodule
